// File: rtl/cpu_host_pkg.sv
// Shared types and constants for the CPU host controller: session FSM states,
// memory strides and the run-phase counter width.
package cpu_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_CAP = 3'd4,
        ST_DUMP_OUT = 3'd5,
        ST_FIN      = 3'd6
    } state_t;

    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;
    localparam int RUN_CNT_W   = 32;

    // First phase with non-zero work, in session order; FIN when nothing is left.
    function automatic state_t first_phase(input logic prog_nz, input logic run_nz, input logic dump_nz);
        state_t ph;
        if (prog_nz) begin
            ph = ST_LOAD;
        end else if (run_nz) begin
            ph = ST_RUN;
        end else if (dump_nz) begin
            ph = ST_DUMP_RD;
        end else begin
            ph = ST_FIN;
        end
        return ph;
    endfunction

endpackage

// File: rtl/cpu_host_ctrl_cycle_timer.sv
// Loadable down-counter with a zero flag; paces how long the core stays enabled.
module cycle_timer
    import cpu_host_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 load,
    input  logic [RUN_CNT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [RUN_CNT_W-1:0] count_r;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_r <= {RUN_CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && !zero) begin
            count_r <= count_r - {{(RUN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {RUN_CNT_W{1'b0}});

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side session sequencer: streams a program into IMEM, enables the core for
// a fixed number of cycles, then streams a DMEM window out. All outputs registered.
module cpu_host_ctrl
    import cpu_host_pkg::*;
#(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic [IMEM_AW:0]     prog_len,
    input  logic [RUN_CNT_W-1:0] run_cycles,
    input  logic [63:0]          dump_base,
    input  logic [DMEM_AW:0]     dump_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [63:0]          m_data,
    output logic                 m_last,
    output logic                 cpu_enable,
    output logic [63:0]          addr_ext,
    output logic                 wen_ext,
    output logic                 ren_ext,
    output logic [31:0]          wdata_ext,
    input  logic [31:0]          rdata_ext,
    output logic [63:0]          addr_ext_2,
    output logic                 wen_ext_2,
    output logic                 ren_ext_2,
    output logic [63:0]          wdata_ext_2,
    input  logic [63:0]          rdata_ext_2,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

    state_t state_r, state_nxt_s, phase_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s;
    logic [IMEM_AW:0]     prog_len_r, prog_len_nxt_s;
    logic [RUN_CNT_W-1:0] run_cycles_r, run_cycles_nxt_s, timer_val_s;
    logic [63:0]          dump_base_r, dump_base_nxt_s;
    logic [DMEM_AW:0]     dump_len_r, dump_len_nxt_s;
    logic                 s_ready_r, s_ready_nxt_s;
    logic                 wen_r, wen_nxt_s;
    logic [63:0]          addr_r, addr_nxt_s;
    logic [31:0]          wdata_r, wdata_nxt_s;
    logic                 ren2_r, ren2_nxt_s;
    logic [63:0]          addr2_r, addr2_nxt_s;
    logic                 m_valid_r, m_valid_nxt_s, m_last_r, m_last_nxt_s;
    logic [63:0]          m_data_r, m_data_nxt_s;
    logic                 cpu_enable_r, busy_r, done_r;
    logic                 timer_load_s, timer_dec_s, timer_zero_s;
    logic                 unused_s;

    cycle_timer u_timer (
        .clk      (clk),
        .arst     (arst),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    // Next-state and next-output decode; registers hold unless a state says otherwise.
    always_comb begin
        state_nxt_s      = state_r;
        phase_s          = ST_FIN;
        idx_nxt_s        = idx_r;
        prog_len_nxt_s   = prog_len_r;
        run_cycles_nxt_s = run_cycles_r;
        dump_base_nxt_s  = dump_base_r;
        dump_len_nxt_s   = dump_len_r;
        s_ready_nxt_s    = 1'b0;
        wen_nxt_s        = 1'b0;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        m_valid_nxt_s    = m_valid_r;
        m_data_nxt_s     = m_data_r;
        m_last_nxt_s     = m_last_r;
        timer_dec_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_s = first_phase(prog_len != {(IMEM_AW+1){1'b0}},
                                      run_cycles != {RUN_CNT_W{1'b0}},
                                      dump_len != {(DMEM_AW+1){1'b0}});
                if (start) begin
                    prog_len_nxt_s   = prog_len;
                    run_cycles_nxt_s = run_cycles;
                    dump_base_nxt_s  = dump_base;
                    dump_len_nxt_s   = dump_len;
                    idx_nxt_s        = {IDX_W{1'b0}};
                    state_nxt_s      = phase_s;
                    s_ready_nxt_s    = (phase_s == ST_LOAD);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // s_ready low inside LOAD means the final write is on the bus now.
                if (s_ready_r && s_valid) begin
                    wen_nxt_s     = 1'b1;
                    addr_nxt_s    = 64'(idx_r[IMEM_AW-1:0]) * 64'(IMEM_STRIDE);
                    wdata_nxt_s   = s_data;
                    idx_nxt_s     = idx_r + IDX_W'(1);
                    s_ready_nxt_s = (idx_r != IDX_W'(prog_len_r) - IDX_W'(1));
                end else if (!s_ready_r) begin
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = first_phase(1'b0, run_cycles_r != {RUN_CNT_W{1'b0}},
                                              dump_len_r != {(DMEM_AW+1){1'b0}});
                end else begin
                    s_ready_nxt_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (timer_zero_s) begin
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = (dump_len_r != {(DMEM_AW+1){1'b0}}) ? ST_DUMP_RD : ST_FIN;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            ST_DUMP_RD: begin
                state_nxt_s = ST_DUMP_CAP;
            end
            ST_DUMP_CAP: begin
                m_data_nxt_s  = rdata_ext_2;
                m_valid_nxt_s = 1'b1;
                m_last_nxt_s  = (idx_r == IDX_W'(dump_len_r) - IDX_W'(1));
                state_nxt_s   = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (m_ready) begin
                    m_valid_nxt_s = 1'b0;
                    m_last_nxt_s  = 1'b0;
                    idx_nxt_s     = idx_r + IDX_W'(1);
                    state_nxt_s   = m_last_r ? ST_FIN : ST_DUMP_RD;
                end else begin
                    state_nxt_s = ST_DUMP_OUT;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        timer_load_s = (state_nxt_s == ST_RUN) && (state_r != ST_RUN);
        timer_val_s  = run_cycles_nxt_s - {{(RUN_CNT_W-1){1'b0}}, 1'b1};
        ren2_nxt_s   = (state_nxt_s == ST_DUMP_RD);
        addr2_nxt_s  = ren2_nxt_s ? dump_base_nxt_s + 64'(idx_nxt_s) * 64'(DMEM_STRIDE) : addr2_r;
    end

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Session parameters, word index and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx_r        <= {IDX_W{1'b0}};
            prog_len_r   <= {(IMEM_AW+1){1'b0}};
            run_cycles_r <= {RUN_CNT_W{1'b0}};
            dump_base_r  <= 64'd0;
            dump_len_r   <= {(DMEM_AW+1){1'b0}};
            s_ready_r    <= 1'b0;
            wen_r        <= 1'b0;
            addr_r       <= 64'd0;
            wdata_r      <= 32'd0;
            ren2_r       <= 1'b0;
            addr2_r      <= 64'd0;
            m_valid_r    <= 1'b0;
            m_data_r     <= 64'd0;
            m_last_r     <= 1'b0;
            cpu_enable_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            idx_r        <= idx_nxt_s;
            prog_len_r   <= prog_len_nxt_s;
            run_cycles_r <= run_cycles_nxt_s;
            dump_base_r  <= dump_base_nxt_s;
            dump_len_r   <= dump_len_nxt_s;
            s_ready_r    <= s_ready_nxt_s;
            wen_r        <= wen_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
            ren2_r       <= ren2_nxt_s;
            addr2_r      <= addr2_nxt_s;
            m_valid_r    <= m_valid_nxt_s;
            m_data_r     <= m_data_nxt_s;
            m_last_r     <= m_last_nxt_s;
            cpu_enable_r <= (state_nxt_s == ST_RUN);
            busy_r       <= (state_nxt_s != ST_IDLE);
            done_r       <= (state_nxt_s == ST_FIN);
        end
    end

    assign s_ready     = s_ready_r;
    assign wen_ext     = wen_r;
    assign addr_ext    = addr_r;
    assign wdata_ext   = wdata_r;
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = ren2_r;
    assign addr_ext_2  = addr2_r;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 64'd0;
    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign m_last      = m_last_r;
    assign cpu_enable  = cpu_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign unused_s    = ^rdata_ext;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Self-checking bench for cpu_host_ctrl: scenario tasks with scoreboard queues
// for IMEM writes, DMEM read addresses and dump-stream words.
module tb_cpu_host_ctrl;

    logic        clk = 1'b0;
    logic        arst, start, s_valid, s_ready, m_valid, m_ready, m_last;
    logic [9:0]  prog_len;
    logic [31:0] run_cycles, s_data, wdata_ext;
    logic [31:0] rdata_ext = 32'd0;
    logic [63:0] dump_base, m_data, addr_ext, addr_ext_2, wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'd0;
    logic [10:0] dump_len;
    logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [95:0] wr_q[$];
    logic [63:0] ra_q[$];
    logic [64:0] rd_q[$];

    always #5 clk = ~clk;

    cpu_host_ctrl dut (
        .clk(clk), .arst(arst), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_len(dump_len), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .addr_ext_2(addr_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
    );

    // DMEM model: registered read, data valid the cycle after ren_ext_2.
    always @(posedge clk) begin
        if (ren_ext_2) begin
            rdata_ext_2 <= (addr_ext_2 == 64'h40) ? 64'h1111 :
                           (addr_ext_2 == 64'h48) ? 64'h2222 : 64'hBAD0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [9:0] pl, input logic [31:0] rc, input logic [63:0] db, input logic [10:0] dl);
        repeat (2) step();
        prog_len = pl; run_cycles = rc; dump_base = db; dump_len = dl;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #3;
        n_checks++;
        if ({s_ready, m_valid, m_last, cpu_enable, wen_ext, ren_ext, ren_ext_2, wen_ext_2, busy, done} !== 10'd0) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0", {s_ready, m_valid, m_last, cpu_enable, wen_ext, ren_ext, ren_ext_2, wen_ext_2, busy, done});
        end
        n_checks++;
        if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, m_data} !== 288'd0) begin
            n_fail++; $display("FAIL reset_buses got=%h want=0", {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, m_data});
        end
        step();
        arst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want=0", busy); end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        logic [95:0] e;
        logic hs;
        int k, nwr, last_wr, done_at, en_seen;
        words = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        for (int i = 0; i < 3; i++) wr_q.push_back({64'(i * 4), words[i]});
        kick(10'd3, 32'd0, 64'd0, 11'd0);
        k = 0; nwr = 0; last_wr = -10; done_at = -1; en_seen = 0;
        s_valid = 1'b1; s_data = words[0];
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            hs = s_valid && s_ready;
            step();
            if (hs) begin
                k++;
                if (k < 3) s_data = words[k]; else s_data = 32'hFFFF_FFFF;
            end
            if (wen_ext) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL load_extra_write addr=%h data=%h", addr_ext, wdata_ext);
                end else begin
                    e = wr_q.pop_front();
                    if ({addr_ext, wdata_ext} !== e) begin
                        n_fail++; $display("FAIL load_write got=%h/%h want=%h/%h", addr_ext, wdata_ext, e[95:32], e[31:0]);
                    end
                end
                if (nwr > 0) begin
                    n_checks++;
                    if (c != last_wr + 1) begin n_fail++; $display("FAIL load_consecutive cycle=%0d want=%0d", c, last_wr + 1); end
                end
                nwr++; last_wr = c;
            end
            if (cpu_enable) en_seen++;
            if (done) done_at = c;
        end
        s_valid = 1'b0;
        n_checks++;
        if (nwr != 3 || wr_q.size() != 0) begin n_fail++; $display("FAIL load_count got=%0d want=3", nwr); end
        n_checks++;
        if (done_at != last_wr + 1) begin n_fail++; $display("FAIL load_done cycle=%0d want=%0d", done_at, last_wr + 1); end
        n_checks++;
        if (en_seen != 0) begin n_fail++; $display("FAIL load_no_run enable_cycles=%0d want=0", en_seen); end
    endtask

    task automatic test_run(input logic [31:0] rc, input bit poke_start);
        int en_cnt, first_en, last_en, done_cnt, done_at;
        en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; done_at = -1;
        kick(10'd0, rc, 64'd0, 11'd0);
        for (int c = 0; c < 40; c++) begin
            if (poke_start && c == 2) begin
                prog_len = 10'd2; run_cycles = 32'd20; dump_len = 11'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cpu_enable) begin
                if (first_en < 0) first_en = c;
                en_cnt++; last_en = c;
            end
            if (done) begin done_cnt++; done_at = c; end
            step();
        end
        start = 1'b0;
        n_checks++;
        if (en_cnt != int'(rc)) begin n_fail++; $display("FAIL run_len got=%0d want=%0d", en_cnt, rc); end
        n_checks++;
        if (first_en != 0 || last_en != int'(rc) - 1) begin
            n_fail++; $display("FAIL run_window got=%0d..%0d want=0..%0d", first_en, last_en, int'(rc) - 1);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != int'(rc)) begin
            n_fail++; $display("FAIL run_done pulses=%0d at=%0d want=1 at %0d", done_cnt, done_at, rc);
        end
    endtask

    task automatic test_dump();
        logic [64:0] e;
        logic [63:0] a;
        int npop, stall, hs_at, done_at;
        ra_q.push_back(64'h40); ra_q.push_back(64'h48);
        rd_q.push_back({1'b0, 64'h1111}); rd_q.push_back({1'b1, 64'h2222});
        m_ready = 1'b0;
        kick(10'd0, 32'd0, 64'h40, 11'd2);
        npop = 0; stall = 0; hs_at = -10; done_at = -1;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            if (ren_ext_2) begin
                n_checks++;
                if (ra_q.size() == 0) begin
                    n_fail++; $display("FAIL dump_extra_read addr=%h", addr_ext_2);
                end else begin
                    a = ra_q.pop_front();
                    if (addr_ext_2 !== a) begin n_fail++; $display("FAIL dump_read_addr got=%h want=%h", addr_ext_2, a); end
                end
            end
            if (m_valid) begin
                if (npop == 0 && stall < 4) begin
                    n_checks++;
                    if ({m_last, m_data} !== rd_q[0]) begin
                        n_fail++; $display("FAIL dump_stall_hold got=%b/%h want=%b/%h", m_last, m_data, rd_q[0][64], rd_q[0][63:0]);
                    end
                    stall++;
                    m_ready = 1'b0;
                end else if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dump_extra_word data=%h", m_data);
                    m_ready = 1'b1;
                end else begin
                    if (npop > 0) begin
                        n_checks++;
                        if (c != hs_at + 3) begin n_fail++; $display("FAIL dump_rate cycle=%0d want=%0d", c, hs_at + 3); end
                    end
                    m_ready = 1'b1;
                    e = rd_q.pop_front();
                    n_checks++;
                    if ({m_last, m_data} !== e) begin
                        n_fail++; $display("FAIL dump_word got=%b/%h want=%b/%h", m_last, m_data, e[64], e[63:0]);
                    end
                    npop++; hs_at = c;
                end
            end else begin
                m_ready = 1'b0;
            end
            if (done) done_at = c;
            step();
        end
        m_ready = 1'b0;
        n_checks++;
        if (npop != 2 || stall != 4 || ra_q.size() != 0) begin
            n_fail++; $display("FAIL dump_count words=%0d stalls=%0d reads_left=%0d want=2/4/0", npop, stall, ra_q.size());
        end
        n_checks++;
        if (done_at != hs_at + 1) begin n_fail++; $display("FAIL dump_done cycle=%0d want=%0d", done_at, hs_at + 1); end
    endtask

    task automatic test_arst();
        logic [95:0] e;
        logic hs;
        int k, nwr, done_at;
        kick(10'd4, 32'd0, 64'd0, 11'd0);
        k = 0; s_valid = 1'b1; s_data = 32'hA000_0000;
        for (int c = 0; c < 20 && k < 2; c++) begin
            hs = s_valid && s_ready;
            step();
            if (hs) begin k++; s_data = 32'hA000_0000 + 32'(k); end
        end
        #2 arst = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, m_valid, m_last, cpu_enable, wen_ext, ren_ext_2, busy, done} !== 8'd0) begin
            n_fail++; $display("FAIL arst_flags got=%b want=0", {s_ready, m_valid, m_last, cpu_enable, wen_ext, ren_ext_2, busy, done});
        end
        n_checks++;
        if ({addr_ext, wdata_ext, addr_ext_2} !== 160'd0) begin
            n_fail++; $display("FAIL arst_buses got=%h want=0", {addr_ext, wdata_ext, addr_ext_2});
        end
        s_valid = 1'b0;
        step();
        arst = 1'b0;
        wr_q.delete();
        wr_q.push_back({64'd0, 32'hDEADBEEF});
        kick(10'd1, 32'd0, 64'd0, 11'd0);
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        nwr = 0; done_at = -1;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            hs = s_valid && s_ready;
            step();
            if (hs) s_data = 32'h0BAD_0BAD;
            if (wen_ext) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL reload_extra_write addr=%h", addr_ext);
                end else begin
                    e = wr_q.pop_front();
                    if ({addr_ext, wdata_ext} !== e) begin
                        n_fail++; $display("FAIL reload_write got=%h/%h want=%h/%h", addr_ext, wdata_ext, e[95:32], e[31:0]);
                    end
                end
                nwr++;
            end
            if (done) done_at = c;
        end
        s_valid = 1'b0;
        n_checks++;
        if (nwr != 1 || done_at != 1) begin n_fail++; $display("FAIL reload_session writes=%0d done_at=%0d want=1/1", nwr, done_at); end
    endtask

    initial begin
        arst = 1'b0; start = 1'b0; prog_len = 10'd0; run_cycles = 32'd0;
        dump_base = 64'd0; dump_len = 11'd0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
        test_reset();
        test_load();
        test_run(32'd5, 1'b0);
        test_dump();
        test_run(32'd6, 1'b1);
        test_arst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
